imu_regs: RTL

Parametrised Avalon-MM slave for the IMU datapath, successor to the fixed six-register IMU controller. It accepts frames of `NUM_CH` simultaneous samples from the ADC sequencer. Each channel is optionally block-averaged over `2^AVG_LOG2` frames. Results are published with coherent multi-channel snapshot reads, new-data/overrun status, a frame counter and an interrupt for the Nios polling/IRQ driver.

---
 rtl/imu_regs_pkg.sv | 18 +
 rtl/imu_ch_avg.sv | 77 +++++++
 rtl/imu_regs.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/imu_regs_pkg.sv
// imu_regs_pkg: shared constants for the IMU register block.
//   - Avalon word addresses of the fixed registers and of the first channel result.
//   - Bit positions inside CTRL and STATUS.
package imu_regs_pkg;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_STATUS    = 4'd1;
    localparam logic [3:0] ADDR_FRAME_CNT = 4'd2;
    localparam logic [3:0] ADDR_CH0       = 4'd4;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_FREEZE  = 1;
    localparam int unsigned CTRL_RESTART = 2;

    localparam int unsigned STAT_FRAME_READY = 0;
    localparam int unsigned STAT_OVERRUN     = 1;

endpackage

// File: rtl/imu_ch_avg.sv
// imu_ch_avg: one channel of the IMU datapath.
//   Holds the block-average accumulator and the published result register.
//   Configuration macro: IMU_REGS_AVG_EN. When undefined there is no
//   accumulator and the result register simply captures the raw sample.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         drop the partial accumulation (restart)      [avg build only]
//   valid         accepted sample this cycle                    [avg build only]
//   last          this sample completes the averaging block     [avg build only]
//   publish       load the result register this cycle
//   sample        signed input sample
//   result        signed published result
module imu_ch_avg
    import imu_regs_pkg::*;
#(
    parameter int DATA_W = 12
`ifdef IMU_REGS_AVG_EN
    ,
    parameter int AVG_LOG2 = 2
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
`ifdef IMU_REGS_AVG_EN
    input  logic                     clear,
    input  logic                     valid,
    input  logic                     last,
`endif
    input  logic                     publish,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] result_q, result_d;

`ifdef IMU_REGS_AVG_EN
    // A full block of 2^AVG_LOG2 samples always fits in DATA_W+AVG_LOG2 bits.
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic signed [ACC_W-1:0] acc_q, acc_d, sum;

    always_comb begin
        sum      = acc_q + ACC_W'(sample);
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (valid) begin
            acc_d = last ? '0 : sum;
        end
        // Arithmetic shift of the signed block sum: rounds toward -inf.
        result_d = publish ? DATA_W'(sum >>> AVG_LOG2) : result_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    always_comb begin
        result_d = publish ? sample : result_q;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/imu_regs.sv
// imu_regs: Avalon-MM slave publishing block-averaged IMU samples.
//   Configuration macro: IMU_REGS_AVG_EN (averaging over 2^AVG_LOG2 frames).
//   Without it every sample_valid is a complete frame and restart is inert.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   chipselect, address,
//   read, write, writedata    Avalon slave request
//   readdata                  registered read data, held between reads
//   sample_valid, sample_data frame strobe and NUM_CH packed signed samples
//   irq                       level interrupt, frame_ready & irq_en
module imu_regs
    import imu_regs_pkg::*;
#(
    parameter int NUM_CH   = 6,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     chipselect,
    input  logic [3:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    output logic                     irq
);

    if (NUM_CH < 1 || NUM_CH > 12 || DATA_W < 2 || DATA_W > 32 ||
        AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_bad_param
        $error("imu_regs: parameter out of legal range");
    end

    logic rd_en, wr_ctrl, rd_status, rd_ch0;
    logic frame_done, publish;

    logic        irq_en_q, irq_en_d;
    logic        freeze_q, freeze_d;
    logic        frame_ready_q, frame_ready_d;
    logic        overrun_q, overrun_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] readdata_q, readdata_d, rd_mux;
    logic        irq_q, irq_d;

    logic signed [DATA_W-1:0] result   [NUM_CH];
    logic signed [DATA_W-1:0] shadow_q [NUM_CH];
    logic signed [DATA_W-1:0] shadow_d [NUM_CH];

    logic unused_bits;

    assign rd_en     = chipselect & read;
    assign wr_ctrl   = chipselect & write & (address == ADDR_CTRL);
    assign rd_status = rd_en & (address == ADDR_STATUS);
    assign rd_ch0    = rd_en & (address == ADDR_CH0);

`ifdef IMU_REGS_AVG_EN
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic             restart, valid, last;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A sample arriving with restart is dropped, not counted.
    assign restart    = wr_ctrl & writedata[CTRL_RESTART];
    assign valid      = sample_valid & ~restart;
    assign last       = (cnt_q == CNT_LAST);
    assign frame_done = valid & last;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (valid) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign unused_bits = ^writedata[31:3];
`else
    assign frame_done  = sample_valid;
    assign unused_bits = ^writedata[31:2];
`endif

    // Frozen frames still advance the accumulators but are never published.
    assign publish = frame_done & ~freeze_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        imu_ch_avg #(
            .DATA_W   (DATA_W)
`ifdef IMU_REGS_AVG_EN
            ,
            .AVG_LOG2 (AVG_LOG2)
`endif
        ) u_avg (
            .clk     (clk),
            .reset_n (reset_n),
`ifdef IMU_REGS_AVG_EN
            .clear   (restart),
            .valid   (valid),
            .last    (last),
`endif
            .publish (publish),
            .sample  (sample_data[k*DATA_W +: DATA_W]),
            .result  (result[k])
        );
    end

    always_comb begin
        rd_mux = '0;
        if (address == ADDR_CTRL) begin
            rd_mux[CTRL_IRQ_EN] = irq_en_q;
            rd_mux[CTRL_FREEZE] = freeze_q;
        end else if (address == ADDR_STATUS) begin
            rd_mux[STAT_FRAME_READY] = frame_ready_q;
            rd_mux[STAT_OVERRUN]     = overrun_q;
        end else if (address == ADDR_FRAME_CNT) begin
            rd_mux[15:0] = frame_cnt_q;
        end else if (address == ADDR_CH0) begin
            rd_mux = 32'(result[0]);
        end else begin
            // Channels above 0 come from the snapshot taken by the last CH0 read.
            for (int unsigned k = 1; k < NUM_CH; k++) begin
                if (address == 4'(ADDR_CH0 + k)) begin
                    rd_mux = 32'(shadow_q[k]);
                end
            end
        end
    end

    always_comb begin
        irq_en_d      = wr_ctrl ? writedata[CTRL_IRQ_EN] : irq_en_q;
        freeze_d      = wr_ctrl ? writedata[CTRL_FREEZE] : freeze_q;
        // Read-clear and set in the same cycle: set wins.
        frame_ready_d = (frame_ready_q & ~rd_status) | publish;
        overrun_d     = (overrun_q & ~rd_status) | (publish & frame_ready_q);
        frame_cnt_d   = publish ? frame_cnt_q + 16'd1 : frame_cnt_q;
        irq_d         = frame_ready_d & irq_en_d;
        readdata_d    = rd_en ? rd_mux : readdata_q;
        shadow_d      = shadow_q;
        if (rd_ch0) begin
            shadow_d = result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q      <= 1'b0;
            freeze_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
            readdata_q    <= '0;
            irq_q         <= 1'b0;
            shadow_q      <= '{default: '0};
        end else begin
            irq_en_q      <= irq_en_d;
            freeze_q      <= freeze_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
            shadow_q      <= shadow_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
